copro_mailbox: RTL and testbench
================================

// Module: copro_mailbox
// PURPOSE
// Parametrised host<->coprocessor mailbox and control block for the 6809 cartridge coprocessor.
// Sits behind the I/O2 register window on the C64 side and a decoded page on the 6809 side.
// Provides the copro control bits (reset, halt, LED) and CHANNELS pairs of byte FIFOs (h2c, c2h).
// Raises an interrupt to either side when that side has mail waiting.
// PARAMETERS
// CHANNELS  2  mailbox channel pairs, 1..4
// DEPTH     4  entries per FIFO, power of 2, >=2
// DATA_W    8  mailbox data width
// PORTS
// clock        in   1       system clock; all logic on its rising edge
// reset        in   1       synchronous, active-high
// host_we      in   1       host write strobe, one cycle, window already decoded
// host_re      in   1       host read strobe, one cycle
// host_addr    in   3       host register offset
// host_wdata   in   DATA_W  host write data
// host_rdata   out  DATA_W  host read data, registered
// cop_we       in   1       copro write strobe
// cop_re       in   1       copro read strobe
// cop_addr     in   3       copro register offset
// cop_wdata    in   DATA_W  copro write data
// cop_rdata    out  DATA_W  copro read data, registered
// _reset_09    out  1       copro reset, active low
// _halt_09     out  1       copro halt, active low
// led          out  1       status LED
// irq_host     out  1       host interrupt, active high, registered
// _firq_09     out  1       copro interrupt, active low, registered
// BEHAVIOUR
// - Reset: _reset_09=0, _halt_09=0, led=0, irq_host=0, _firq_09=1, rdata=0; all FIFOs empty; irq enables 0.
// - Host map: 0 CONFIG rw {b7 _reset_09, b6 _halt_09, b5 host_irq_en, b1 flush (W1, self-clearing, reads 0), b0 led}.
//   1 STATUS ro {[3:0] c2h not-empty, [7:4] h2c full}; unused channel bits read 0.
//   2+c DATA c: write pushes h2c[c]; read pops c2h[c].
// - Copro map: 0 STATUS ro {[3:0] h2c not-empty, [7:4] c2h full}; 1 IRQCTL rw {b0 cop_irq_en}.
//   2+c DATA c: write pushes c2h[c]; read pops h2c[c].
// - Offsets >= 2+CHANNELS: writes ignored; reads return 0.
// - Read latency: rdata updates one clock after re and holds until the next re.
//   Popped data is the head entry at the re cycle.
// - Push to a full FIFO is dropped, with no state change. Pop from an empty FIFO returns 0 and leaves pointers unchanged.
// - Simultaneous push and pop on one FIFO:
//   - Both take effect.
//   - When full: pop returns the head, push is accepted, count stays DEPTH.
//   - When empty: no bypass; pop returns 0, push is accepted, count becomes 1.
// - Pointers wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits, so 0 and DEPTH are distinguished.
// - Flush empties all 2*CHANNELS FIFOs in the cycle after the write. A same-cycle cop_we push is lost.
// - While _reset_09=0, copro strobes are ignored and cop_rdata holds. Host accesses stay live.
// - Host and copro accesses to different FIFOs in the same cycle are independent.
// - irq_host <= host_irq_en & |c2h_not_empty; _firq_09 <= ~(cop_irq_en & |h2c_not_empty). Both are one cycle after the FIFO state.
// - Reset asserted mid-operation: every state element returns to its reset value at that edge, in-flight reads included.
// STRUCTURE
// - copro_pkg: register offsets, CONFIG/STATUS bit positions, MAX_CHANNELS=4.
// - Sub-module mailbox_fifo (DEPTH, DATA_W): synchronous FIFO with push, pop, flush, head, full, empty, count.
//   Instantiated 2*CHANNELS times via generate.
// - Top level holds the address decode, CONFIG/IRQCTL registers, read muxes and IRQ flops.
// TESTING
// - Release reset, host writes CONFIG=0xC1 -> _reset_09=1, _halt_09=1, led=1; host reads CONFIG -> 0xC1.
// - Host writes 0x11,0x22,0x33,0x44,0x55 to DATA0 (DEPTH=4) -> host STATUS b4=1.
//   Copro pops 4 -> 0x11..0x44; 5th pop -> 0x00; 0x55 never appears.
// - Copro IRQCTL=1, host pushes 0xA5 to DATA1 -> _firq_09=0 two cycles after the push.
//   Copro reads DATA1 -> 0xA5; _firq_09=1 after the FIFO empties.
// - Fill c2h0 to full, then copro push 0x77 and host pop in the same cycle -> host gets the old head, count stays 4, 0x77 is last out.
// - 3 entries queued in each FIFO, host writes CONFIG b1=1 -> STATUS=0x00 on both sides; irq_host=0.
// - With _reset_09=0, copro writes DATA0=0x99 -> c2h0 stays empty.
//   Assert reset with FIFOs non-empty -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/copro_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : copro_pkg
//  Description : Register offsets and bit positions for the coprocessor
//                mailbox, shared by the host and copro decode logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package copro_pkg;

    localparam int MAX_CHANNELS = 4;

    // Host-side register offsets
    localparam logic [2:0] c_host_config = 3'd0;
    localparam logic [2:0] c_host_status = 3'd1;

    // Copro-side register offsets
    localparam logic [2:0] c_cop_status  = 3'd0;
    localparam logic [2:0] c_cop_irqctl  = 3'd1;

    // DATA c lives at c_off_data0 + c on both sides
    localparam logic [2:0] c_off_data0   = 3'd2;

    // CONFIG bit positions
    localparam int c_cfg_reset_n = 7;
    localparam int c_cfg_halt_n  = 6;
    localparam int c_cfg_irq_en  = 5;
    localparam int c_cfg_flush   = 1;
    localparam int c_cfg_led     = 0;

    // IRQCTL bit position
    localparam int c_irqctl_en   = 0;

endpackage
`default_nettype wire

// File: rtl/mailbox_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mailbox_fifo
//  Description : Synchronous byte FIFO with push, pop and flush. A push to a
//                full FIFO is accepted only when a pop frees a slot that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mailbox_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | i_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{c_aw{1'b0}}, w_push_ok} - {{c_aw{1'b0}}, w_pop_ok};
        end
    end

    // Storage needs no reset: the head is never observed while empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/copro_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : copro_mailbox
//  Description : Host <-> 6809 coprocessor mailbox: control register, per
//                channel h2c/c2h FIFOs, registered read ports and interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module copro_mailbox
    import copro_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_we,
    input  logic              host_re,
    input  logic [2:0]        host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              cop_we,
    input  logic              cop_re,
    input  logic [2:0]        cop_addr,
    input  logic [DATA_W-1:0] cop_wdata,
    output logic [DATA_W-1:0] cop_rdata,
    output logic              _reset_09,
    output logic              _halt_09,
    output logic              led,
    output logic              irq_host,
    output logic              _firq_09
);

    localparam int c_cw = $clog2(DEPTH) + 1;

    logic r_cfg_reset_n, r_cfg_halt_n, r_host_irq_en, r_led, r_cop_irq_en;
    logic r_irq_host, r_firq_n;
    logic [DATA_W-1:0] r_host_rdata, r_cop_rdata;

    logic [CHANNELS-1:0] w_h2c_full, w_h2c_empty, w_c2h_full, w_c2h_empty;
    logic [CHANNELS-1:0][c_cw-1:0]   w_h2c_count, w_c2h_count;
    logic [CHANNELS:0][DATA_W-1:0]   w_host_acc, w_cop_acc;
    logic [MAX_CHANNELS-1:0] w_h2c_ne, w_h2c_full4, w_c2h_ne, w_c2h_full4;
    logic [DATA_W-1:0] w_host_rd, w_cop_rd;
    logic w_cop_we, w_cop_re, w_host_cfg_we, w_flush;
    logic w_unused_counts;

    // The copro side is frozen while it is held in reset.
    assign w_cop_we      = cop_we & r_cfg_reset_n;
    assign w_cop_re      = cop_re & r_cfg_reset_n;
    assign w_host_cfg_we = host_we && (host_addr == c_host_config);
    assign w_flush       = w_host_cfg_we & host_wdata[c_cfg_flush];

    assign w_host_acc[0] = '0;
    assign w_cop_acc[0]  = '0;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            localparam logic [2:0] c_addr = 3'(c_off_data0 + 3'(g));
            logic [DATA_W-1:0] w_h2c_head, w_c2h_head;

            mailbox_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_h2c (
                .clk     (clock),
                .rst     (reset),
                .i_push  (host_we && (host_addr == c_addr)),
                .i_pop   (w_cop_re && (cop_addr == c_addr)),
                .i_flush (w_flush),
                .i_wdata (host_wdata),
                .o_head  (w_h2c_head),
                .o_full  (w_h2c_full[g]),
                .o_empty (w_h2c_empty[g]),
                .o_count (w_h2c_count[g])
            );

            mailbox_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_c2h (
                .clk     (clock),
                .rst     (reset),
                .i_push  (w_cop_we && (cop_addr == c_addr)),
                .i_pop   (host_re && (host_addr == c_addr)),
                .i_flush (w_flush),
                .i_wdata (cop_wdata),
                .o_head  (w_c2h_head),
                .o_full  (w_c2h_full[g]),
                .o_empty (w_c2h_empty[g]),
                .o_count (w_c2h_count[g])
            );

            // OR-chain of per-channel read data; a miss or empty FIFO adds 0.
            assign w_host_acc[g+1] = w_host_acc[g] |
                (((host_addr == c_addr) && !w_c2h_empty[g]) ? w_c2h_head : '0);
            assign w_cop_acc[g+1]  = w_cop_acc[g] |
                (((cop_addr == c_addr) && !w_h2c_empty[g]) ? w_h2c_head : '0);
        end
    endgenerate

    assign w_unused_counts = ^{w_h2c_count, w_c2h_count};

    always_comb begin
        w_h2c_ne    = '0;
        w_h2c_full4 = '0;
        w_c2h_ne    = '0;
        w_c2h_full4 = '0;
        w_h2c_ne[CHANNELS-1:0]    = ~w_h2c_empty;
        w_h2c_full4[CHANNELS-1:0] = w_h2c_full;
        w_c2h_ne[CHANNELS-1:0]    = ~w_c2h_empty;
        w_c2h_full4[CHANNELS-1:0] = w_c2h_full;
    end

    always_comb begin
        w_host_rd = '0;
        case (host_addr)
            c_host_config: begin
                w_host_rd[c_cfg_reset_n] = r_cfg_reset_n;
                w_host_rd[c_cfg_halt_n]  = r_cfg_halt_n;
                w_host_rd[c_cfg_irq_en]  = r_host_irq_en;
                w_host_rd[c_cfg_led]     = r_led;
            end
            c_host_status: w_host_rd[7:0] = {w_h2c_full4, w_c2h_ne};
            default:       w_host_rd = w_host_acc[CHANNELS];
        endcase
    end

    always_comb begin
        w_cop_rd = '0;
        case (cop_addr)
            c_cop_status: w_cop_rd[7:0] = {w_c2h_full4, w_h2c_ne};
            c_cop_irqctl: w_cop_rd[c_irqctl_en] = r_cop_irq_en;
            default:      w_cop_rd = w_cop_acc[CHANNELS];
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cfg_reset_n <= 1'b0;
            r_cfg_halt_n  <= 1'b0;
            r_host_irq_en <= 1'b0;
            r_led         <= 1'b0;
            r_cop_irq_en  <= 1'b0;
            r_host_rdata  <= '0;
            r_cop_rdata   <= '0;
            r_irq_host    <= 1'b0;
            r_firq_n      <= 1'b1;
        end else begin
            if (w_host_cfg_we) begin
                r_cfg_reset_n <= host_wdata[c_cfg_reset_n];
                r_cfg_halt_n  <= host_wdata[c_cfg_halt_n];
                r_host_irq_en <= host_wdata[c_cfg_irq_en];
                r_led         <= host_wdata[c_cfg_led];
            end
            if (w_cop_we && (cop_addr == c_cop_irqctl))
                r_cop_irq_en <= cop_wdata[c_irqctl_en];
            if (host_re)  r_host_rdata <= w_host_rd;
            if (w_cop_re) r_cop_rdata  <= w_cop_rd;
            r_irq_host <= r_host_irq_en & (|w_c2h_ne);
            r_firq_n   <= ~(r_cop_irq_en & (|w_h2c_ne));
        end
    end

    assign host_rdata = r_host_rdata;
    assign cop_rdata  = r_cop_rdata;
    assign _reset_09  = r_cfg_reset_n;
    assign _halt_09   = r_cfg_halt_n;
    assign led        = r_led;
    assign irq_host   = r_irq_host;
    assign _firq_09   = r_firq_n;

endmodule
`default_nettype wire

// File: tb/tb_copro_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_copro_mailbox
//  Description : Self-checking bench for copro_mailbox against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_copro_mailbox;

    localparam int CH    = 2;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       host_we, host_re, cop_we, cop_re;
    logic [2:0] host_addr, cop_addr;
    logic [7:0] host_wdata, cop_wdata, host_rdata, cop_rdata;
    logic       reset09_n, halt09_n, led, irq_host, firq_n;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    copro_mailbox #(.CHANNELS(CH), .DEPTH(DEPTH), .DATA_W(8)) dut (
        .clock(clock), .reset(reset),
        .host_we(host_we), .host_re(host_re), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .cop_we(cop_we), .cop_re(cop_re), .cop_addr(cop_addr),
        .cop_wdata(cop_wdata), .cop_rdata(cop_rdata),
        ._reset_09(reset09_n), ._halt_09(halt09_n), .led(led),
        .irq_host(irq_host), ._firq_09(firq_n)
    );

    // Reference model: one queue per FIFO plus the visible registers.
    logic [7:0] m_h2c [CH][$];
    logic [7:0] m_c2h [CH][$];
    logic       m_reset_n, m_halt_n, m_irq_en, m_led, m_cop_irq_en;
    logic       m_irq_host, m_firq_n;
    logic [7:0] m_host_rdata, m_cop_rdata;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_h2c[c].delete();
            m_c2h[c].delete();
        end
        {m_reset_n, m_halt_n, m_irq_en, m_led, m_cop_irq_en, m_irq_host} = '0;
        m_firq_n = 1'b1;
        m_host_rdata = 8'h00;
        m_cop_rdata  = 8'h00;
    endtask

    function automatic logic [7:0] host_view(input logic [2:0] a);
        logic [7:0] v;
        int idx;
        v = 8'h00;
        idx = int'(a) - 2;
        if (a == 3'd0) v = {m_reset_n, m_halt_n, m_irq_en, 4'b0000, m_led};
        else if (a == 3'd1) begin
            for (int c = 0; c < CH; c++) begin
                v[c]   = (m_c2h[c].size() != 0);
                v[4+c] = (m_h2c[c].size() == DEPTH);
            end
        end else if (idx < CH && m_c2h[idx].size() != 0) v = m_c2h[idx][0];
        return v;
    endfunction

    function automatic logic [7:0] cop_view(input logic [2:0] a);
        logic [7:0] v;
        int idx;
        v = 8'h00;
        idx = int'(a) - 2;
        if (a == 3'd0) begin
            for (int c = 0; c < CH; c++) begin
                v[c]   = (m_h2c[c].size() != 0);
                v[4+c] = (m_c2h[c].size() == DEPTH);
            end
        end else if (a == 3'd1) v = {7'b0, m_cop_irq_en};
        else if (idx < CH && m_h2c[idx].size() != 0) v = m_h2c[idx][0];
        return v;
    endfunction

    // Drive one clock of strobes and advance the model by the same cycle.
    task automatic step(input logic hwe, input logic hre, input logic [2:0] ha, input logic [7:0] hwd,
                        input logic cwe, input logic cre, input logic [2:0] ca, input logic [7:0] cwd);
        logic nxt_irq, nxt_firq, live, flush, any_c2h, any_h2c;
        int hi, ci;
        host_we = hwe; host_re = hre; host_addr = ha; host_wdata = hwd;
        cop_we  = cwe; cop_re  = cre; cop_addr  = ca; cop_wdata  = cwd;
        hi = int'(ha) - 2;
        ci = int'(ca) - 2;
        any_c2h = 1'b0;
        any_h2c = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (m_c2h[c].size() != 0) any_c2h = 1'b1;
            if (m_h2c[c].size() != 0) any_h2c = 1'b1;
        end
        nxt_irq  = m_irq_en & any_c2h;
        nxt_firq = ~(m_cop_irq_en & any_h2c);
        live  = m_reset_n;
        flush = hwe && ha == 3'd0 && hwd[1];
        if (hre) m_host_rdata = host_view(ha);
        if (live && cre) m_cop_rdata = cop_view(ca);
        if (hre && hi >= 0 && hi < CH && m_c2h[hi].size() != 0) void'(m_c2h[hi].pop_front());
        if (live && cre && ci >= 0 && ci < CH && m_h2c[ci].size() != 0) void'(m_h2c[ci].pop_front());
        if (hwe && hi >= 0 && hi < CH && m_h2c[hi].size() < DEPTH) m_h2c[hi].push_back(hwd);
        if (live && cwe && ci >= 0 && ci < CH && m_c2h[ci].size() < DEPTH) m_c2h[ci].push_back(cwd);
        if (flush) begin
            for (int c = 0; c < CH; c++) begin
                m_h2c[c].delete();
                m_c2h[c].delete();
            end
        end
        if (hwe && ha == 3'd0) {m_reset_n, m_halt_n, m_irq_en, m_led} = {hwd[7], hwd[6], hwd[5], hwd[0]};
        if (live && cwe && ca == 3'd1) m_cop_irq_en = cwd[0];
        m_irq_host = nxt_irq;
        m_firq_n   = nxt_firq;
        @(posedge clock);
        #1;
        {host_we, host_re, cop_we, cop_re} = '0;
    endtask

    task automatic idle();
        step(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
    endtask

    task automatic test_reset();
        checks++;
        if ({reset09_n, halt09_n, led, irq_host, firq_n} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp %b", {reset09_n, halt09_n, led, irq_host, firq_n}, 5'b00001);
        end
        checks++;
        if ({host_rdata, cop_rdata} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata got %h exp %h", {host_rdata, cop_rdata}, 16'h0000);
        end
    endtask

    task automatic test_config();
        step(1, 0, 3'd0, 8'hC1, 0, 0, 3'd0, 8'h00);
        checks++;
        if ({reset09_n, halt09_n, led} !== 3'b111) begin
            errors++;
            $display("FAIL cfg_outputs got %b exp %b", {reset09_n, halt09_n, led}, 3'b111);
        end
        step(0, 1, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
        checks++;
        if (host_rdata !== 8'hC1) begin
            errors++;
            $display("FAIL cfg_read got %h exp %h", host_rdata, 8'hC1);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp [5];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        for (int i = 0; i < 5; i++) step(1, 0, 3'd2, 8'(8'h11 * (i + 1)), 0, 0, 3'd0, 8'h00);
        step(0, 1, 3'd1, 8'h00, 0, 0, 3'd0, 8'h00);
        checks++;
        if (host_rdata !== 8'h10) begin
            errors++;
            $display("FAIL full_status got %h exp %h", host_rdata, 8'h10);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 3'd0, 8'h00, 0, 1, 3'd2, 8'h00);
            checks++;
            if (cop_rdata !== exp[i]) begin
                errors++;
                $display("FAIL full_pop%0d got %h exp %h", i, cop_rdata, exp[i]);
            end
        end
    endtask

    task automatic test_irq();
        step(0, 0, 3'd0, 8'h00, 1, 0, 3'd1, 8'h01);
        step(1, 0, 3'd3, 8'hA5, 0, 0, 3'd0, 8'h00);
        checks++;
        if (firq_n !== 1'b1) begin
            errors++;
            $display("FAIL firq_early got %b exp %b", firq_n, 1'b1);
        end
        idle();
        checks++;
        if (firq_n !== 1'b0) begin
            errors++;
            $display("FAIL firq_assert got %b exp %b", firq_n, 1'b0);
        end
        step(0, 0, 3'd0, 8'h00, 0, 1, 3'd3, 8'h00);
        checks++;
        if (cop_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL irq_data got %h exp %h", cop_rdata, 8'hA5);
        end
        idle();
        checks++;
        if (firq_n !== 1'b1) begin
            errors++;
            $display("FAIL firq_release got %b exp %b", firq_n, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [5];
        exp = '{8'h02, 8'h03, 8'h04, 8'h77, 8'h00};
        for (int i = 1; i <= 4; i++) step(0, 0, 3'd0, 8'h00, 1, 0, 3'd2, 8'(i));
        step(0, 1, 3'd2, 8'h00, 1, 0, 3'd2, 8'h77);
        checks++;
        if (host_rdata !== 8'h01) begin
            errors++;
            $display("FAIL b2b_head got %h exp %h", host_rdata, 8'h01);
        end
        step(0, 0, 3'd0, 8'h00, 0, 1, 3'd0, 8'h00);
        checks++;
        if (cop_rdata !== 8'h10) begin
            errors++;
            $display("FAIL b2b_still_full got %h exp %h", cop_rdata, 8'h10);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 3'd2, 8'h00, 0, 0, 3'd0, 8'h00);
            checks++;
            if (host_rdata !== exp[i]) begin
                errors++;
                $display("FAIL b2b_pop%0d got %h exp %h", i, host_rdata, exp[i]);
            end
        end
    endtask

    task automatic test_flush();
        step(1, 0, 3'd0, 8'hE1, 0, 0, 3'd0, 8'h00);
        for (int i = 0; i < 6; i++)
            step(1, 0, 3'(2 + i % 2), 8'(8'h30 + i), 1, 0, 3'(2 + i % 2), 8'(8'h60 + i));
        step(0, 1, 3'd1, 8'h00, 0, 0, 3'd0, 8'h00);
        checks++;
        if ({host_rdata, irq_host, firq_n} !== {8'h03, 2'b10}) begin
            errors++;
            $display("FAIL pre_flush got %h exp %h", {host_rdata, irq_host, firq_n}, {8'h03, 2'b10});
        end
        step(1, 0, 3'd0, 8'hE3, 1, 0, 3'd2, 8'h99);
        step(0, 1, 3'd1, 8'h00, 0, 1, 3'd0, 8'h00);
        checks++;
        if ({host_rdata, cop_rdata} !== 16'h0000) begin
            errors++;
            $display("FAIL flush_status got %h exp %h", {host_rdata, cop_rdata}, 16'h0000);
        end
        checks++;
        if ({irq_host, firq_n} !== 2'b01) begin
            errors++;
            $display("FAIL flush_irq got %b exp %b", {irq_host, firq_n}, 2'b01);
        end
        step(0, 1, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
        checks++;
        if (host_rdata !== 8'hE1) begin
            errors++;
            $display("FAIL flush_selfclear got %h exp %h", host_rdata, 8'hE1);
        end
    endtask

    task automatic test_copro_held();
        step(0, 0, 3'd0, 8'h00, 0, 1, 3'd1, 8'h00);
        step(1, 0, 3'd0, 8'h41, 0, 0, 3'd0, 8'h00);
        step(0, 0, 3'd0, 8'h00, 1, 1, 3'd2, 8'h99);
        checks++;
        if ({reset09_n, cop_rdata} !== {1'b0, 8'h01}) begin
            errors++;
            $display("FAIL held_cop got %h exp %h", {reset09_n, cop_rdata}, {1'b0, 8'h01});
        end
        step(0, 1, 3'd1, 8'h00, 0, 0, 3'd0, 8'h00);
        checks++;
        if (host_rdata !== 8'h00) begin
            errors++;
            $display("FAIL held_status got %h exp %h", host_rdata, 8'h00);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 3'd0, 8'hE1, 0, 0, 3'd0, 8'h00);
        step(1, 0, 3'd2, 8'h5A, 1, 0, 3'd2, 8'h6B);
        step(0, 1, 3'd0, 8'h00, 0, 1, 3'd0, 8'h00);
        checks++;
        if ({irq_host, host_rdata, cop_rdata} !== {1'b1, 8'hE1, 8'h01}) begin
            errors++;
            $display("FAIL pre_reset got %h exp %h", {irq_host, host_rdata, cop_rdata}, {1'b1, 8'hE1, 8'h01});
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        checks++;
        if ({reset09_n, halt09_n, led, irq_host, firq_n, host_rdata, cop_rdata} !== {5'b00001, 16'h0000}) begin
            errors++;
            $display("FAIL mid_reset got %h exp %h",
                     {reset09_n, halt09_n, led, irq_host, firq_n, host_rdata, cop_rdata}, {5'b00001, 16'h0000});
        end
        step(0, 1, 3'd1, 8'h00, 0, 0, 3'd0, 8'h00);
        checks++;
        if (host_rdata !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_empty got %h exp %h", host_rdata, 8'h00);
        end
    endtask

    task automatic test_random();
        logic hwe, hre, cwe, cre;
        logic [2:0] ha, ca;
        logic [7:0] hwd, cwd;
        step(1, 0, 3'd0, 8'hE1, 1, 0, 3'd1, 8'h01);
        for (int n = 0; n < 400; n++) begin
            hwe = ($urandom_range(0, 9) < 4);
            hre = ($urandom_range(0, 9) < 4);
            cwe = ($urandom_range(0, 9) < 4);
            cre = ($urandom_range(0, 9) < 4);
            ha  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 3));
            ca  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 3));
            hwd = 8'($urandom);
            cwd = 8'($urandom);
            if (ha == 3'd0) begin
                hwd[7] = ($urandom_range(0, 7) != 0);
                hwd[1] = ($urandom_range(0, 15) == 0);
            end
            step(hwe, hre, ha, hwd, cwe, cre, ca, cwd);
            checks++;
            if (host_rdata !== m_host_rdata) begin
                errors++;
                $display("FAIL rnd_host_rdata n=%0d got %h exp %h", n, host_rdata, m_host_rdata);
            end
            checks++;
            if (cop_rdata !== m_cop_rdata) begin
                errors++;
                $display("FAIL rnd_cop_rdata n=%0d got %h exp %h", n, cop_rdata, m_cop_rdata);
            end
            checks++;
            if ({irq_host, firq_n} !== {m_irq_host, m_firq_n}) begin
                errors++;
                $display("FAIL rnd_irq n=%0d got %b exp %b", n, {irq_host, firq_n}, {m_irq_host, m_firq_n});
            end
            checks++;
            if ({reset09_n, halt09_n, led} !== {m_reset_n, m_halt_n, m_led}) begin
                errors++;
                $display("FAIL rnd_ctrl n=%0d got %b exp %b", n, {reset09_n, halt09_n, led}, {m_reset_n, m_halt_n, m_led});
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        {host_we, host_re, cop_we, cop_re} = '0;
        host_addr = 3'd0; cop_addr = 3'd0;
        host_wdata = 8'h00; cop_wdata = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        test_reset();
        test_config();
        test_fifo_full();
        test_irq();
        test_back_to_back();
        test_flush();
        test_copro_held();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
